// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one registered ALU between two requesters,
// keeping a single op in flight and returning tagged results on a response port.
module alu_req_arbiter #(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * OPER_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OPER_WIDTH-1:0] req0_a,
  input  logic [OPER_WIDTH-1:0] req0_b,
  input  logic [3:0]            req0_fun,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OPER_WIDTH-1:0] req1_a,
  input  logic [OPER_WIDTH-1:0] req1_b,
  input  logic [3:0]            req1_fun,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [OUT_WIDTH-1:0]  rsp_data,
  output logic                  rsp_id,
  output logic                  rsp_err,
  output logic [OPER_WIDTH-1:0] alu_a,
  output logic [OPER_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_fun,
  output logic                  alu_en,
  input  logic [OUT_WIDTH-1:0]  alu_out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [3:0] FUN_DIV = 4'b0011;

  state_t                state_reg, state_next;
  logic                  last_grant_reg, last_grant_next;
  logic [OPER_WIDTH-1:0] alu_a_reg, alu_a_next;
  logic [OPER_WIDTH-1:0] alu_b_reg, alu_b_next;
  logic [3:0]            alu_fun_reg, alu_fun_next;
  logic                  alu_en_reg, alu_en_next;
  logic                  rsp_valid_reg, rsp_valid_next;
  logic [OUT_WIDTH-1:0]  rsp_data_reg, rsp_data_next;
  logic                  rsp_id_reg, rsp_id_next;
  logic                  rsp_err_reg, rsp_err_next;

  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic                  any_valid;
  logic                  grant;
  logic [OPER_WIDTH-1:0] sel_a;
  logic [OPER_WIDTH-1:0] sel_b;
  logic [3:0]            sel_fun;
  logic                  sel_div0;

  assign req_valid = {req1_valid, req0_valid};
  assign any_valid = |req_valid;
  // With both requesting, the one not served last wins; otherwise the lone requester.
  assign grant     = (&req_valid) ? ~last_grant_reg : req_valid[1];

  assign sel_a    = grant ? req1_a   : req0_a;
  assign sel_b    = grant ? req1_b   : req0_b;
  assign sel_fun  = grant ? req1_fun : req0_fun;
  assign sel_div0 = (sel_fun == FUN_DIV) && (sel_b == '0);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign req_ready[gi] = (state_reg == IDLE) && any_valid &&
                             ((gi == 1) ? grant : ~grant);
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      alu_a_reg      <= '0;
      alu_b_reg      <= '0;
      alu_fun_reg    <= '0;
      alu_en_reg     <= 1'b0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_id_reg     <= 1'b0;
      rsp_err_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      alu_a_reg      <= alu_a_next;
      alu_b_reg      <= alu_b_next;
      alu_fun_reg    <= alu_fun_next;
      alu_en_reg     <= alu_en_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_data_reg   <= rsp_data_next;
      rsp_id_reg     <= rsp_id_next;
      rsp_err_reg    <= rsp_err_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    alu_a_next      = alu_a_reg;
    alu_b_next      = alu_b_reg;
    alu_fun_next    = alu_fun_reg;
    alu_en_next     = 1'b0;
    rsp_valid_next  = rsp_valid_reg;
    rsp_data_next   = rsp_data_reg;
    rsp_id_next     = rsp_id_reg;
    rsp_err_next    = rsp_err_reg;
    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          alu_a_next      = sel_a;
          alu_b_next      = sel_b;
          alu_fun_next    = sel_fun;
          rsp_id_next     = grant;
          last_grant_next = grant;
          // Divide by zero is answered locally without touching the ALU.
          if (sel_div0) begin
            rsp_data_next  = '0;
            rsp_err_next   = 1'b1;
            rsp_valid_next = 1'b1;
            state_next     = RESP;
          end else begin
            alu_en_next = 1'b1;
            state_next  = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_next = CAPTURE;
      end
      CAPTURE: begin
        rsp_data_next  = alu_out;
        rsp_err_next   = 1'b0;
        rsp_valid_next = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_fun   = alu_fun_reg;
  assign alu_en    = alu_en_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_id    = rsp_id_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a registered ALU model, a response scoreboard and
// one task per scenario (reset, latency, div0, hold, alternation, mid-op reset).
module tb_alu_req_arbiter;
  localparam int OW = 8;
  localparam int RW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [OW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]    req0_fun = '0, req1_fun = '0;
  logic          rsp_valid, rsp_id, rsp_err;
  logic          rsp_ready = 1'b1;
  logic [RW-1:0] rsp_data;
  logic [OW-1:0] alu_a, alu_b;
  logic [3:0]    alu_fun;
  logic          alu_en;
  logic [RW-1:0] alu_out;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic          id;
    logic [RW-1:0] data;
    logic          err;
  } exp_t;

  exp_t sb[$];
  logic id_log[$];
  int   cyc = 0;
  int   hs_cyc = 0;
  int   rise_cyc = 0;
  int   alu_en_cnt = 0;
  bit   hs0 = 0, hs1 = 0;
  logic rsp_prev = 1'b0;

  always #5 CLK = ~CLK;

  alu_req_arbiter #(.OPER_WIDTH(OW), .OUT_WIDTH(RW)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_fun(req0_fun),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_fun(req1_fun),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_out(alu_out)
  );

  function automatic logic [RW-1:0] alu_f(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                          input logic [3:0] f);
    case (f)
      4'b0000: alu_f = RW'(a) + RW'(b);
      4'b0001: alu_f = RW'(a) - RW'(b);
      4'b0010: alu_f = RW'(a) * RW'(b);
      4'b0011: alu_f = (b != 0) ? RW'(a / b) : '0;
      default: alu_f = '0;
    endcase
  endfunction

  function automatic exp_t mk(input logic id, input logic [OW-1:0] a, input logic [OW-1:0] b,
                              input logic [3:0] f);
    exp_t e;
    e.id   = id;
    e.err  = (f == 4'b0011) && (b == 0);
    e.data = e.err ? '0 : alu_f(a, b, f);
    return e;
  endfunction

  // External registered ALU
  always @(posedge CLK or negedge RST) begin
    if (!RST) alu_out <= '0;
    else if (alu_en) alu_out <= alu_f(alu_a, alu_b, alu_fun);
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: push on accepted request, pop and compare on taken response
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      checks++;
      if (req0_ready && req1_ready) begin
        failures++;
        $display("FAIL both_ready cyc=%0d req0_ready=1 req1_ready=1 required at most one", cyc);
      end
      if (req0_valid && req0_ready) begin
        sb.push_back(mk(1'b0, req0_a, req0_b, req0_fun)); hs_cyc = cyc; hs0 = 1;
      end
      if (req1_valid && req1_ready) begin
        sb.push_back(mk(1'b1, req1_a, req1_b, req1_fun)); hs_cyc = cyc; hs1 = 1;
      end
      if (alu_en) alu_en_cnt++;
      if (rsp_valid && !rsp_prev) rise_cyc = cyc;
      rsp_prev = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected cyc=%0d id=%0d data=%h err=%0d required none",
                   cyc, rsp_id, rsp_data, rsp_err);
        end else begin
          e = sb.pop_front();
          if ({rsp_id, rsp_data, rsp_err} !== e) begin
            failures++;
            $display("FAIL rsp_compare cyc=%0d got id=%0d data=%h err=%0d required id=%0d data=%h err=%0d",
                     cyc, rsp_id, rsp_data, rsp_err, e.id, e.data, e.err);
          end
          id_log.push_back(rsp_id);
        end
      end
    end else begin
      rsp_prev = 1'b0;
    end
  end

  task automatic do_reset();
    RST = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    sb.delete();
    RST = 1'b1;
  endtask

  task automatic drive(input logic id, input logic [OW-1:0] a, input logic [OW-1:0] b,
                       input logic [3:0] f);
    int n;
    @(posedge CLK); #1;
    if (id) begin req1_a = a; req1_b = b; req1_fun = f; req1_valid = 1'b1; end
    else    begin req0_a = a; req0_b = b; req0_fun = f; req0_valid = 1'b1; end
    n = 0;
    do begin @(negedge CLK); n++; end while (!(id ? req1_ready : req0_ready) && n < 50);
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL accept_timeout id=%0d waited=%0d cycles required ready", id, n);
    end
    @(posedge CLK); #1;
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while ((sb.size() != 0 || rsp_valid) && n < 100) begin @(negedge CLK); n++; end
    checks++;
    if (n >= 100) begin
      failures++;
      $display("FAIL %s_timeout pending=%0d rsp_valid=%0d required drained", tag, sb.size(), rsp_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge CLK);
    checks++;
    if ({rsp_valid, alu_en, rsp_id, rsp_err, req0_ready, req1_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got valid=%0d en=%0d id=%0d err=%0d rdy0=%0d rdy1=%0d required all 0",
               rsp_valid, alu_en, rsp_id, rsp_err, req0_ready, req1_ready);
    end
    checks++;
    if ({alu_a, alu_b, alu_fun} !== 20'h0) begin
      failures++;
      $display("FAIL reset_alu got a=%h b=%h fun=%h required 0", alu_a, alu_b, alu_fun);
    end
    checks++;
    if (rsp_data !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got %h required 0000", rsp_data);
    end
  endtask

  task automatic test_single();
    alu_en_cnt = 0;
    drive(1'b0, 8'd200, 8'd100, 4'b0000);
    wait_done("single");
    checks++;
    if (rise_cyc - hs_cyc !== 3) begin
      failures++;
      $display("FAIL single_latency got %0d required 3", rise_cyc - hs_cyc);
    end
    checks++;
    if (alu_en_cnt !== 1) begin
      failures++;
      $display("FAIL single_en_cycles got %0d required 1", alu_en_cnt);
    end
  endtask

  task automatic test_div0();
    alu_en_cnt = 0;
    drive(1'b1, 8'd9, 8'd0, 4'b0011);
    wait_done("div0");
    checks++;
    if (rise_cyc - hs_cyc !== 1) begin
      failures++;
      $display("FAIL div0_latency got %0d required 1", rise_cyc - hs_cyc);
    end
    checks++;
    if (alu_en_cnt !== 0) begin
      failures++;
      $display("FAIL div0_en_cycles got %0d required 0", alu_en_cnt);
    end
  endtask

  task automatic test_fun15();
    alu_en_cnt = 0;
    drive(1'b0, 8'd3, 8'd3, 4'b1111);
    wait_done("fun15");
    checks++;
    if (alu_en_cnt !== 1 || rise_cyc - hs_cyc !== 3) begin
      failures++;
      $display("FAIL fun15_issue got en_cycles=%0d latency=%0d required 1 and 3",
               alu_en_cnt, rise_cyc - hs_cyc);
    end
  endtask

  task automatic test_hold();
    int n;
    rsp_ready = 1'b0;
    drive(1'b0, 8'd255, 8'd255, 4'b0010);
    req1_a = 8'd5; req1_b = 8'd7; req1_fun = 4'b0000; req1_valid = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!rsp_valid && n < 20);
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL hold_rsp_timeout waited=%0d required rsp_valid", n);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge CLK);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hFE01 || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable i=%0d got valid=%0d data=%h id=%0d rdy0=%0d rdy1=%0d required 1 fe01 0 0 0",
                 i, rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready);
      end
    end
    @(posedge CLK); #1;
    rsp_ready = 1'b1;
    n = 0;
    do begin @(negedge CLK); n++; end while (!req1_ready && n < 20);
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL hold_req1_timeout waited=%0d required req1_ready", n);
    end
    @(posedge CLK); #1;
    req1_valid = 1'b0;
    wait_done("hold");
  endtask

  task automatic test_alternate();
    int n;
    do_reset();
    id_log.delete();
    req0_a = 8'd1;  req0_b = 8'd2; req0_fun = 4'b0000;
    req1_a = 8'd10; req1_b = 8'd3; req1_fun = 4'b0001;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    hs0 = 0; hs1 = 0;
    n = 0;
    while (id_log.size() < 8 && n < 300) begin
      @(posedge CLK); #1; n++;
      if (hs0) begin
        req0_a = 8'($urandom); req0_b = 8'($urandom_range(0, 3)); req0_fun = 4'($urandom_range(0, 3)); hs0 = 0;
      end
      if (hs1) begin
        req1_a = 8'($urandom); req1_b = 8'($urandom_range(0, 3)); req1_fun = 4'($urandom_range(0, 3)); hs1 = 0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_done("alternate");
    checks++;
    if (id_log.size() < 8) begin
      failures++;
      $display("FAIL alt_count got %0d responses required 8", id_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (id_log[i] !== 1'(i % 2)) begin
          failures++;
          $display("FAIL alt_order op=%0d got id=%0d required %0d", i, id_log[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit leaked = 0;
    drive(1'b0, 8'd20, 8'd30, 4'b0001);
    @(negedge CLK);
    @(negedge CLK);
    #1 RST = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || alu_en !== 1'b0 || alu_a !== 8'h0 || alu_fun !== 4'h0) begin
      failures++;
      $display("FAIL midrst_outputs got valid=%0d en=%0d a=%h fun=%h required 0",
               rsp_valid, alu_en, alu_a, alu_fun);
    end
    sb.delete();
    @(posedge CLK); #1;
    RST = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (rsp_valid) leaked = 1;
    end
    checks++;
    if (leaked) begin
      failures++;
      $display("FAIL midrst_discard got rsp_valid=1 after reset required 0");
    end
    drive(1'b1, 8'd7, 8'd6, 4'b0010);
    wait_done("midrst");
    checks++;
    if (rise_cyc - hs_cyc !== 3) begin
      failures++;
      $display("FAIL midrst_latency got %0d required 3", rise_cyc - hs_cyc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_div0();
    test_fun15();
    test_hold();
    test_alternate();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
